pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Sequences the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage MIPS core.
- Each cycle it drives every latch's enable/flush pair, the PC enable and the instruction-read request.
- It arbitrates the shared cache port (dmem over imem), detects load-use hazards, squashes on taken branch/jump, and latches halt.
- It also keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction read complete this cycle
dhit  in  1  data access complete this cycle
mem_dREN  in  1  EX/MEM latch output: load in MEM stage
mem_dWEN  in  1  EX/MEM latch output: store in MEM stage
mem_pc_redirect  in  1  branch taken or jump/JR/JAL resolved in MEM stage
ex_MemtoReg  in  1  ID/EX latch output: load in EX stage
ex_regWEN  in  1  ID/EX latch output: EX instruction writes a register
ex_wsel  in  5  ID/EX latch output: EX destination register
id_rs  in  5  IF/ID instruction rs
id_rt  in  5  IF/ID instruction rt
id_uses_rt  in  1  ID instruction reads rt
wb_halt  in  1  MEM/WB latch out_halt
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flushes (flush beats en inside the latch)
pc_en  out  1  PC register update
imemREN  out  1  instruction read request
halt  out  1  CPU halted, sticky
stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted
flush_cnt  out  CNT_W  count of redirect squashes

Behaviour:
- Reset: state=RUN, halt=0, counters=0. Combinational outputs follow the RUN equations.
- FSM states: RUN, DWAIT, HALTED.
  - RUN->DWAIT: (mem_dREN|mem_dWEN) & !dhit.
  - DWAIT->RUN: dhit.
  - any->HALTED: wb_halt. HALTED exits only on nRST.
- halt is registered: asserts the cycle after wb_halt is sampled.
- Case priority, first match wins.
  - HALTED: all en=0, all flush=0, pc_en=0, imemREN=0.
  - Data stall, (mem_dREN|mem_dWEN) & !dhit (RUN or DWAIT): all en=0, flush=0, pc_en=0, imemREN=0.
  - Data complete, dhit with access: exmem_en=memwb_en=idex_en=1, pc_en=0.
    - No load-use: ifid_flush=1 (no instruction was fetched).
    - Load-use: ifid_en=0, ifid_flush=0, idex_flush=1.
  - Redirect, mem_pc_redirect: ifid_flush=idex_flush=exmem_flush=1, memwb_en=1, pc_en=1. ihit is ignored.
  - Load-use: ex_MemtoReg & ex_regWEN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
    - ifid_en=0, pc_en=0, idex_flush=1, exmem_en=memwb_en=1.
  - Fetch wait, !ihit: ifid_flush=1, pc_en=0, idex_en=exmem_en=memwb_en=1.
  - Run: all en=1, pc_en=1.
- imemREN=1 in RUN/DWAIT whenever no data access is in MEM.
- All outputs not named in a case are 0.
- stall_cnt increments on any non-halted cycle with pc_en=0. flush_cnt increments on each redirect cycle.
- Both counters saturate at all-ones (no wrap) and freeze in HALTED.
- Reset mid-stall returns to RUN immediately. Outputs re-evaluate asynchronously.

Decomposition:
- cpu_types_pkg gets pctrl_state_t (RUN, DWAIT, HALTED) and a regbits_t-typed zero-register constant.
- One sub-module, sat_counter (CNT_W, inc, count), instantiated twice.
- Hazard equations stay inline.

Test Plan:
1. Reset, then ihit=1 and no hazards for 5 cycles -> all en=1, pc_en=1, imemREN=1, stall_cnt=0.
2. Load in MEM, dhit low 3 cycles then high -> 3 cycles all en=0/imemREN=0; dhit cycle ifid_flush=1, pc_en=0; stall_cnt=4; state back to RUN.
3. ex_MemtoReg=1, ex_regWEN=1, ex_wsel=8, id_rs=8 -> ifid_en=0, pc_en=0, idex_flush=1. Repeat with ex_wsel=0 -> no stall.
4. mem_pc_redirect=1 with ihit=0 -> ifid/idex/exmem_flush=1, pc_en=1, flush_cnt increments by 1.
5. wb_halt=1 -> next cycle halt=1, all en=0, imemREN=0; further inputs ignored until nRST.
6. Preload stall_cnt near max (CNT_W=4) with a 20-cycle dmem stall -> stall_cnt holds 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the MIPS core control path.
//   regbits_t     : 5-bit register index
//   ZERO_REG      : $zero, which never creates a data hazard
//   pctrl_state_t : pipeline controller sequencing state
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    localparam regbits_t ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: performance counter that counts up on inc and sticks at all-ones.
//   CLK, nRST : clock, async active-low reset (clears count)
//   inc       : count this cycle
//   count     : current value, saturates at 2**CNT_W-1
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + ONE;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall/flush sequencer for the 5-stage MIPS pipeline.
//   CLK, nRST              : clock, async active-low reset
//   ihit, dhit             : imem / dmem access completed this cycle
//   mem_dREN, mem_dWEN     : load / store sitting in MEM
//   mem_pc_redirect        : taken branch or jump resolved in MEM
//   ex_MemtoReg, ex_regWEN, ex_wsel : EX instruction load/write/destination
//   id_rs, id_rt, id_uses_rt        : ID instruction source registers
//   wb_halt                : halt instruction reached WB
//   *_en, *_flush          : latch controls (flush overrides en in the latch)
//   pc_en, imemREN         : PC update, instruction read request
//   halt                   : sticky halted flag
//   stall_cnt, flush_cnt   : saturating stall / redirect counters
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_pc_redirect,
    input  logic             ex_MemtoReg,
    input  logic             ex_regWEN,
    input  regbits_t         ex_wsel,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_uses_rt,
    input  logic             wb_halt,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             pc_en,
    output logic             imemREN,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pctrl_state_t state, next_state;
    logic         halted;
    logic         daccess;
    logic         loaduse;
    logic         redirect_sq;

    assign halted  = (state == HALTED);
    assign daccess = mem_dREN | mem_dWEN;
    assign loaduse = ex_MemtoReg & ex_regWEN & (ex_wsel != ZERO_REG) &
                     ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
            halt  <= 1'b0;
        end else begin
            state <= next_state;
            halt  <= halt | wb_halt;
        end
    end

    always_comb begin
        next_state = state;
        if (wb_halt)
            next_state = HALTED;
        else begin
            case (state)
                RUN:     if (daccess && !dhit) next_state = DWAIT;
                DWAIT:   if (dhit) next_state = RUN;
                default: next_state = state;
            endcase
        end
    end

    // Priority chain: halted, data stall, data complete, redirect,
    // load-use, fetch wait, free run.
    always_comb begin
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_en       = 1'b0;
        redirect_sq = 1'b0;
        // The shared cache port belongs to dmem whenever MEM holds an access.
        imemREN     = !halted && !daccess;

        if (halted) begin
            // everything frozen
        end else if (daccess && !dhit) begin
            // whole pipe waits for dmem
        end else if (daccess) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            // imem lost the port this cycle, so IF/ID holds nothing valid
            // unless a load-use bubble must keep ID in place instead.
            if (loaduse)
                idex_flush = 1'b1;
            else
                ifid_flush = 1'b1;
        end else if (mem_pc_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
            pc_en       = 1'b1;
            redirect_sq = 1'b1;
        end else if (loaduse) begin
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else if (!ihit) begin
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else begin
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            pc_en    = 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (!halted && !pc_en),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (redirect_sq),
        .count (flush_cnt)
    );

endmodule
